spi_slave_port: RTL
===================

Name: spi_slave_port

Overview:
SPI mode-0 responder that terminates the far end of the SPI bus the Picoblaze-side master drives. It lets the master read and write an 8-bit-addressed register space in the fabric, which makes it usable as an on-chip loopback target and as a stand-in for the accelerometer.
- SCLK, MOSI and nCS are oversampled on clk.
- Serial frames are decoded into single-cycle register write strobes and register read requests.
- MISO is shifted out from the read data.
- Requirement: SCLK frequency ≤ clk/8.

Parameters:
CMD_WRITE, 8'h0A, command byte selecting a register write frame
CMD_READ, 8'h0B, command byte selecting a register read frame
SYNC_STAGES, 2, synchronizer flops on sclk/mosi/ncs (legal range 2..3)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sclk  input  1  SPI clock from master, asynchronous, idle low
mosi  input  1  SPI data from master, asynchronous
ncs  input  1  SPI chip select, active low, asynchronous
miso  output  1  SPI data to master
miso_oe  output  1  MISO output enable (pad tri-stated when 0)
reg_addr  output  8  current register address
reg_wr  output  1  one-cycle write strobe
reg_wdata  output  8  write data, valid while reg_wr=1
reg_rd  output  1  one-cycle read request
reg_rdata  input  8  read data, sampled the clk after reg_rd
busy  output  1  frame in progress (synchronized ncs low)

Behaviour:
- Reset values: miso=0, miso_oe=0, reg_addr=0, reg_wr=0, reg_wdata=0, reg_rd=0, busy=0, FSM=IDLE, bit counter=0, shift registers=0.
- Synchronization: sclk, mosi and ncs each pass through SYNC_STAGES flops. Rising and falling edges of sclk are detected from the last two synchronized samples.
- Edge usage: MOSI is sampled on the detected sclk rising edge. MISO changes on the detected sclk falling edge.
- Byte assembly: MSB first. A 3-bit counter advances on each rising edge; a byte is complete on count 7.
- FSM states:
  - IDLE: synchronized ncs falling edge -> CMD, bit counter cleared, busy=1.
  - CMD: byte complete. CMD_WRITE -> ADDR_W; CMD_READ -> ADDR_R; any other value -> IGNORE.
  - ADDR_W: byte complete -> reg_addr=byte, then WDATA.
  - ADDR_R: byte complete -> reg_addr=byte, reg_rd pulse next clk, then RDATA.
  - WDATA: each complete byte -> reg_wdata=byte with a one-cycle reg_wr pulse on the clk after the byte completes. Stay in WDATA.
  - RDATA: reg_rdata is loaded into the tx shift register the clk after reg_rd.
    - miso_oe=1 and miso=tx[7] immediately on load, i.e. before the first falling edge of the data byte.
    - The register shifts on each falling edge.
    - After the 8th rising edge of a data byte, a new reg_rd is issued and reloaded for the next byte.
  - IGNORE: consume clocks. No strobes, miso_oe=0.
- End of frame: synchronized ncs high in any state -> IDLE next clk.
  - miso_oe=0, busy=0, bit counter=0.
  - A partial byte is discarded with no strobe.
  - reg_addr holds its last value.
- Reset mid-frame: immediate return to reset values. The block waits for a fresh ncs falling edge; a frame already in progress is ignored until ncs rises.
- Strobes: reg_wr and reg_rd are never asserted in the same cycle and are never asserted while ncs is high.
- Address arithmetic: 8-bit, wraps 8'hFF -> 8'h00.

Optional Feature:
SPI_SLAVE_BURST_EN
- Defined: after each data byte of a write or read frame, reg_addr increments by 1 (wrapping at 8'hFF). This happens on the clk of reg_wr, or of the tx reload for reads. Multi-byte frames therefore access consecutive registers.
- Undefined: reg_addr stays fixed for the whole frame. Repeated data bytes rewrite, or re-read, the same address.

Test Plan:
- Write frame 0A,12,5A; ncs rises -> exactly one reg_wr with reg_addr=8'h12, reg_wdata=8'h5A. miso_oe=0 throughout.
- Read frame 0B,20,00 with reg_rdata=8'hC3 -> one reg_rd at reg_addr=8'h20. Master samples 8'hC3 on the third byte. miso_oe is 0 again within SYNC_STAGES+2 clk after ncs rises.
- Burst write 0A,FE,11,22,33:
  - With SPI_SLAVE_BURST_EN: reg_wr at addresses FE,FF,00 with data 11,22,33.
  - Without it: three reg_wr all at FE.
- Bad command 0C,12,5A -> no reg_wr and no reg_rd, miso_oe=0.
- Abort: ncs rises after 4 bits of the data byte in 0A,12,xx -> no reg_wr. A following 0A,13,77 frame writes 77 to 13 correctly.
- Reset asserted mid-read frame -> all outputs at reset values next clk. The remainder of that frame produces no strobes, and the next full frame works.

Source files
------------

// File: rtl/spi_slave_port.sv
// SPI mode-0 register-access responder: oversamples sclk/mosi/ncs on clk and turns frames into reg strobes.
// Optional macro SPI_SLAVE_BURST_EN: auto-increment reg_addr after every data byte of a frame.
module spi_slave_port #(
    parameter logic [7:0] CMD_WRITE   = 8'h0A,
    parameter logic [7:0] CMD_READ    = 8'h0B,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ncs,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] reg_addr,
    output logic       reg_wr,
    output logic [7:0] reg_wdata,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR_W, ADDR_R, WDATA, RDATA, IGNORE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ncs_prev_q, ncs_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic                   rd_q, rd_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   busy_q, busy_d;

    logic       sclk_s, mosi_s, ncs_s;
    logic       sclk_rise, sclk_fall, ncs_fall;
    logic [7:0] rx_byte;
    logic       byte_done;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign rx_byte   = {rx_q[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        sclk_prev_d = sclk_s;
        ncs_prev_d  = ncs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        busy_d      = busy_q;

        // Only a fresh ncs falling edge starts a frame, so a frame cut by reset stays ignored.
        if (state_q == IDLE) begin
            if (ncs_fall) begin
                state_d   = CMD;
                bit_cnt_d = 3'd0;
                rx_d      = 8'h00;
                busy_d    = 1'b1;
            end
        end else if (ncs_s) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            if (sclk_rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            unique case (state_q)
                CMD: begin
                    if (byte_done) begin
                        state_d = (rx_byte == CMD_WRITE) ? ADDR_W :
                                  (rx_byte == CMD_READ)  ? ADDR_R : IGNORE;
                    end
                end
                ADDR_W: begin
                    if (byte_done) begin
                        addr_d  = rx_byte;
                        state_d = WDATA;
                    end
                end
                ADDR_R: begin
                    if (byte_done) begin
                        addr_d  = rx_byte;
                        rd_d    = 1'b1;
                        state_d = RDATA;
                    end
                end
                WDATA: begin
                    if (byte_done) begin
                        wdata_d = rx_byte;
                        wr_d    = 1'b1;
                    end
                    if (BURST_EN && wr_q) begin
                        addr_d = addr_q + 8'd1;
                    end
                end
                RDATA: begin
                    // The fall closing the previous byte (count 0) must not shift out the freshly loaded MSB.
                    if (rd_q) begin
                        tx_d      = reg_rdata;
                        miso_d    = reg_rdata[7];
                        miso_oe_d = 1'b1;
                        if (BURST_EN) begin
                            addr_d = addr_q + 8'd1;
                        end
                    end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
                        tx_d   = {tx_q[6:0], 1'b0};
                        miso_d = tx_q[6];
                    end
                    if (byte_done) begin
                        rd_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign reg_addr  = addr_q;
    assign reg_wr    = wr_q;
    assign reg_wdata = wdata_q;
    assign reg_rd    = rd_q;
    assign busy      = busy_q;

endmodule
